// File: rtl/wb_sdram_arbiter_pkg.sv
// rtl/wb_sdram_arbiter_pkg.sv - shared state encodings and default widths for the SDRAM Wishbone arbiter
package wb_sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_TIMEOUT    = 255;

endpackage

// File: rtl/wb_arb_rr2.sv
// rtl/wb_arb_rr2.sv - two-way round-robin grant picker; on a tie the port that did not win last time wins
module wb_arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// rtl/wb_sdram_arbiter.sv - two-master round-robin Wishbone arbiter in front of the SDRAM controller
// Optional ack watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_sdram_arbiter
  import wb_sdram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  output logic [1:0]            gnt_o,
  output logic [CNT_WIDTH-1:0]  xfer_cnt0_o,
  output logic [CNT_WIDTH-1:0]  xfer_cnt1_o
);

  arb_state_t           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [1:0]           req, pick;
  logic                 cur_stb;
  logic                 tmo_hit;

  assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  wb_arb_rr2 u_rr2 (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .gnt_o        (pick)
  );

  assign cur_stb     = (state_q == GNT0) ? m0_stb_i : (state_q == GNT1) ? m1_stb_i : 1'b0;
  assign gnt_o       = state_q;
  assign xfer_cnt0_o = cnt0_q;
  assign xfer_cnt1_o = cnt1_q;
  assign m0_err_o    = tmo_hit && (state_q == GNT0);
  assign m1_err_o    = tmo_hit && (state_q == GNT1);

  // Slave side and master returns are steered purely by the registered grant.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    case (state_q)
      GNT0: begin
        s_cyc_o  = m0_cyc_i & ~tmo_hit;
        s_stb_o  = m0_stb_i & ~tmo_hit;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i & m0_stb_i;
        m0_dat_o = s_dat_i;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i & ~tmo_hit;
        s_stb_o  = m1_stb_i & ~tmo_hit;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i & m1_stb_i;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    case (state_q)
      IDLE: begin
        if (pick[0])      state_d = GNT0;
        else if (pick[1]) state_d = GNT1;
      end
      GNT0: begin
        if (m0_stb_i && s_ack_i && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_WIDTH'(1);
        if (!m0_cyc_i || tmo_hit) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end
      GNT1: begin
        if (m1_stb_i && s_ack_i && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_WIDTH'(1);
        if (!m1_cyc_i || tmo_hit) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            stall;

  // The clock that would take the count to TIMEOUT is the one that errors out.
  assign stall   = (state_q != IDLE) && cur_stb && !s_ack_i;
  assign tmo_hit = stall && (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    wd_d = wd_q;
    if ((state_q == IDLE) || (state_d == IDLE) || s_ack_i) wd_d = '0;
    else if (stall)                                          wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// tb/tb_wb_sdram_arbiter.sv - directed self-checking bench for the SDRAM Wishbone arbiter
module tb_wb_sdram_arbiter;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;
  logic [15:0] xfer_cnt0_o, xfer_cnt1_o;

  int checks = 0;
  int errors = 0;

  always #5 wb_clk = ~wb_clk;

  wb_sdram_arbiter #(.TIMEOUT(8)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o), .xfer_cnt0_o(xfer_cnt0_o), .xfer_cnt1_o(xfer_cnt1_o)
  );

  task automatic step();
    @(posedge wb_clk);
    #2;
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_sel_i = 4'hF; m0_adr_i = adr; m0_dat_i = dat;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_sel_i = 4'hF; m1_adr_i = adr; m1_dat_i = dat;
  endtask

  task automatic do_reset();
    set_m0(0, 0, 0, 32'h0, 32'h0);
    set_m1(0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b0;
    s_dat_i = 32'h0;
    wb_rst  = 1'b1;
    step();
    step();
    wb_rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b exp 00", gnt_o); end
    checks++; if ({s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 6'b0) begin
      errors++; $display("FAIL rst_ctl got %b exp 000000", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
    end
    checks++; if ({xfer_cnt0_o, xfer_cnt1_o} !== 32'h0) begin
      errors++; $display("FAIL rst_cnt got %h exp 00000000", {xfer_cnt0_o, xfer_cnt1_o});
    end
    set_m0(1, 1, 1, 32'h40, 32'h11);
    step();
    #1;
    checks++; if ({gnt_o, s_cyc_o} !== 3'b011) begin errors++; $display("FAIL rst_pre_gnt got %b exp 011", {gnt_o, s_cyc_o}); end
    s_ack_i = 1'b1;
    step();
    checks++; if (xfer_cnt0_o !== 16'd1) begin errors++; $display("FAIL rst_pre_cnt got %0d exp 1", xfer_cnt0_o); end
    wb_rst = 1'b1;
    #1;
    checks++; if ({s_cyc_o, gnt_o, m0_ack_o} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid got %b exp 0000", {s_cyc_o, gnt_o, m0_ack_o});
    end
    checks++; if (xfer_cnt0_o !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d exp 0", xfer_cnt0_o); end
    set_m0(0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b0;
    step();
    wb_rst = 1'b0;
    step();
    checks++; if ({gnt_o, xfer_cnt0_o, xfer_cnt1_o} !== 34'h0) begin
      errors++; $display("FAIL rst_after got %h exp 0", {gnt_o, xfer_cnt0_o, xfer_cnt1_o});
    end
  endtask

  task automatic test_single_write();
    do_reset();
    set_m0(1, 1, 1, 32'h0, 32'h0000ABCD);
    #1;
    checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL sw_latency got %b exp 0", s_cyc_o); end
    step();
    #1;
    checks++; if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o} !== 7'b1111111) begin
      errors++; $display("FAIL sw_ctl got %b exp 1111111", {s_cyc_o, s_stb_o, s_we_o, s_sel_o});
    end
    checks++; if ({s_adr_o, s_dat_o} !== {32'h0, 32'h0000ABCD}) begin
      errors++; $display("FAIL sw_adr_dat got %h exp 000000000000abcd", {s_adr_o, s_dat_o});
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL sw_early_ack%0d got %b exp 0", i, m0_ack_o); end
      step();
    end
    s_ack_i = 1'b1;
    #1;
    checks++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin errors++; $display("FAIL sw_ack got %b exp 10", {m0_ack_o, m1_ack_o}); end
    step();
    set_m0(0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b0;
    #1;
    checks++; if ({m0_ack_o, s_cyc_o} !== 2'b00) begin errors++; $display("FAIL sw_ack_len got %b exp 00", {m0_ack_o, s_cyc_o}); end
    checks++; if ({xfer_cnt0_o, xfer_cnt1_o} !== {16'd1, 16'd0}) begin
      errors++; $display("FAIL sw_cnt got %h exp 00010000", {xfer_cnt0_o, xfer_cnt1_o});
    end
    step();
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL sw_release got %b exp 00", gnt_o); end
  endtask

  task automatic test_tie_break();
    do_reset();
    set_m0(1, 1, 1, 32'h100, 32'hA0A0A0A0);
    set_m1(1, 1, 0, 32'h200, 32'h0);
    step();
    #1;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL tie1_gnt got %b exp 01", gnt_o); end
    checks++; if (s_adr_o !== 32'h100) begin errors++; $display("FAIL tie1_adr got %h exp 00000100", s_adr_o); end
    s_ack_i = 1'b1;
    s_dat_i = 32'hDEADBEEF;
    #1;
    checks++; if ({m0_ack_o, m1_ack_o, m1_dat_o} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL tie1_ack got %h exp 200000000", {m0_ack_o, m1_ack_o, m1_dat_o});
    end
    step();
    set_m0(0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b0;
    #1;
    checks++; if ({gnt_o, s_cyc_o} !== 3'b010) begin errors++; $display("FAIL tie1_drop got %b exp 010", {gnt_o, s_cyc_o}); end
    step();
    checks++; if ({gnt_o, s_cyc_o} !== 3'b000) begin errors++; $display("FAIL tie_bubble got %b exp 000", {gnt_o, s_cyc_o}); end
    step();
    checks++; if ({gnt_o, s_we_o, s_adr_o} !== {2'b10, 1'b0, 32'h200}) begin
      errors++; $display("FAIL tie2_gnt got %h exp 400000200", {gnt_o, s_we_o, s_adr_o});
    end
    s_ack_i = 1'b1;
    s_dat_i = 32'h12345678;
    #1;
    checks++; if ({m1_ack_o, m1_dat_o} !== {1'b1, 32'h12345678}) begin
      errors++; $display("FAIL tie2_rdata got %h exp 112345678", {m1_ack_o, m1_dat_o});
    end
    checks++; if ({m0_ack_o, m0_dat_o} !== 33'h0) begin
      errors++; $display("FAIL tie2_m0_quiet got %h exp 0", {m0_ack_o, m0_dat_o});
    end
    step();
    set_m1(0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b0;
    step();
    set_m0(1, 1, 1, 32'h104, 32'h1);
    set_m1(1, 1, 0, 32'h204, 32'h0);
    step();
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL tie3_alternate got %b exp 01", gnt_o); end
    checks++; if ({xfer_cnt0_o, xfer_cnt1_o} !== {16'd1, 16'd1}) begin
      errors++; $display("FAIL tie_cnt got %h exp 00010001", {xfer_cnt0_o, xfer_cnt1_o});
    end
    set_m0(0, 0, 0, 32'h0, 32'h0);
    set_m1(0, 0, 0, 32'h0, 32'h0);
    step();
    step();
  endtask

  task automatic test_no_preempt();
    logic [1:0] beat_stb_ack [6];
    beat_stb_ack = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b11, 2'b11};
    do_reset();
    set_m1(1, 1, 0, 32'h300, 32'h0);
    step();
    set_m0(1, 1, 1, 32'h400, 32'h5);
    for (int i = 0; i < 6; i++) begin
      m1_stb_i = beat_stb_ack[i][1];
      s_ack_i  = beat_stb_ack[i][0];
      #1;
      checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL np_hold%0d got %b exp 10", i, gnt_o); end
      checks++; if ({m1_ack_o, m0_ack_o} !== {beat_stb_ack[i][1] & beat_stb_ack[i][0], 1'b0}) begin
        errors++; $display("FAIL np_ack%0d got %b exp %b", i, {m1_ack_o, m0_ack_o}, {beat_stb_ack[i][1] & beat_stb_ack[i][0], 1'b0});
      end
      step();
    end
    set_m1(0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b0;
    step();
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL np_bubble got %b exp 00", gnt_o); end
    step();
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL np_m0_after got %b exp 01", gnt_o); end
    checks++; if ({xfer_cnt0_o, xfer_cnt1_o} !== {16'd0, 16'd4}) begin
      errors++; $display("FAIL np_cnt got %h exp 00000004", {xfer_cnt0_o, xfer_cnt1_o});
    end
    set_m0(0, 0, 0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    set_m1(1, 1, 0, 32'h500, 32'h0);
    s_ack_i = 1'b1;
    step();
    repeat (65534) step();
    checks++; if (xfer_cnt1_o !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h exp fffe", xfer_cnt1_o); end
    step();
    checks++; if (xfer_cnt1_o !== 16'hFFFF) begin errors++; $display("FAIL sat_top got %h exp ffff", xfer_cnt1_o); end
    step();
    step();
    checks++; if ({xfer_cnt1_o, xfer_cnt0_o} !== {16'hFFFF, 16'h0}) begin
      errors++; $display("FAIL sat_nowrap got %h exp ffff0000", {xfer_cnt1_o, xfer_cnt0_o});
    end
    set_m1(0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b0;
    step();
    step();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    set_m0(1, 1, 0, 32'h600, 32'h0);
    set_m1(1, 1, 0, 32'h700, 32'h0);
    step();
    for (int k = 1; k <= 7; k++) begin
      #1;
      checks++; if ({m0_err_o, s_cyc_o} !== 2'b01) begin errors++; $display("FAIL tmo_stall%0d got %b exp 01", k, {m0_err_o, s_cyc_o}); end
      step();
    end
    #1;
    checks++; if ({m0_err_o, m1_err_o, s_cyc_o, s_stb_o} !== 4'b1000) begin
      errors++; $display("FAIL tmo_fire got %b exp 1000", {m0_err_o, m1_err_o, s_cyc_o, s_stb_o});
    end
    step();
    set_m0(0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 1'b1;
    #1;
    checks++; if ({gnt_o, m0_ack_o, m0_err_o} !== 4'b0000) begin
      errors++; $display("FAIL tmo_idle got %b exp 0000", {gnt_o, m0_ack_o, m0_err_o});
    end
    step();
    s_ack_i = 1'b0;
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL tmo_m1_gnt got %b exp 10", gnt_o); end
    set_m1(0, 0, 0, 32'h0, 32'h0);
    step();
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_tie_break();
    test_no_preempt();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_sdram_arbiter.md
Name: wb_sdram_arbiter

Overview:
Two-master, one-slave Wishbone arbiter in front of wb_sdram_ctrl. Port 0 is the USB-ingest writer (FIFO-to-SDRAM path). Port 1 is the USB-egress reader (SDRAM-to-FIFO path). Round-robin grant, held for a whole Wishbone cycle, so the two fpga-level state-machine paths can share the single SDRAM controller without collision.

Parameters:
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width
SEL_WIDTH, DATA_WIDTH/8, byte-select width
CNT_WIDTH, 16, width of the per-port completed-transfer counters
TIMEOUT, 255, ack-timeout limit in clocks (used only with WB_ARB_TIMEOUT_EN)

Ports:
wb_clk  in  1  clock (single clock domain)
wb_rst  in  1  asynchronous, active-high reset
m0_cyc_i, m0_stb_i, m0_we_i  in  1  master 0 cycle/strobe/write
m0_sel_i  in  SEL_WIDTH  master 0 byte select
m0_adr_i  in  ADDR_WIDTH  master 0 address
m0_dat_i  in  DATA_WIDTH  master 0 write data
m0_dat_o  out  DATA_WIDTH  master 0 read data
m0_ack_o, m0_err_o  out  1  master 0 ack / error
m1_* (all of the above)  same  same  master 1 equivalents
s_cyc_o, s_stb_o, s_we_o  out  1  to slave
s_sel_o  out  SEL_WIDTH  to slave
s_adr_o  out  ADDR_WIDTH  to slave
s_dat_o  out  DATA_WIDTH  to slave
s_dat_i  in  DATA_WIDTH  slave read data
s_ack_i  in  1  slave ack
gnt_o  out  2  one-hot current grant; 00 = none
xfer_cnt0_o, xfer_cnt1_o  out  CNT_WIDTH  acks delivered per port, saturating

Behaviour:
- Request: req[n] = mn_cyc_i & mn_stb_i.
- States: IDLE, GNT0, GNT1. Registered grant.
- Reset value of every output is 0, applied asynchronously: state=IDLE, gnt_o=00, s_* outputs 0, all ack/err 0, counters 0, last_grant=1 (so port 0 wins the first tie).
- IDLE transitions:
  - only req0 -> GNT0
  - only req1 -> GNT1
  - both -> port != last_grant
  - none -> IDLE
- Arbitration latency: 1 clock from request to s_cyc_o.
- In GNTn:
  - s_cyc/stb/we/sel/adr/dat_o are combinational copies of master n. s_cyc_o = mn_cyc_i, so the slave sees cyc drop in the same cycle.
  - mn_ack_o = s_ack_i. mn_dat_o = s_dat_i.
  - The non-granted master sees ack=0, err=0, dat_o=0.
- Grant is held while mn_cyc_i=1, including multiple stb/ack beats inside one cycle. No preemption.
- Release: mn_cyc_i=0 in GNTn -> IDLE next clock, last_grant<=n. This gives one idle bubble before the next grant, even if the other port is waiting.
- Ack arriving with stb=0 (stray): not forwarded, not counted.
- Counters: xfer_cntn increments on each cycle where state=GNTn, mn_stb_i=1 and s_ack_i=1. Saturates at all-ones; no wrap.
- Reset mid-transfer: s_cyc_o drops immediately; any ack in flight is lost. Masters must restart.
- gnt_o: GNT0 -> 01, GNT1 -> 10, IDLE -> 00.

Optional Feature:
WB_ARB_TIMEOUT_EN
- Defined:
  - An 8-bit (clog2(TIMEOUT+1)) watchdog counts clocks in GNTn with stb=1 and no ack; it clears on ack or on leaving GNTn.
  - When the count reaches TIMEOUT, mn_err_o pulses for 1 clock, s_cyc_o/s_stb_o are forced 0 from that clock, and the state returns to IDLE next clock with last_grant<=n.
  - The master must drop cyc. A late s_ack_i after the timeout is ignored.
- Undefined: no watchdog; err outputs tied 0; a hung slave blocks the bus forever.

Decomposition:
- Shared package/header: state encodings (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10), default widths, TIMEOUT default.
- One sub-module is natural: wb_arb_rr2, a 2-way round-robin grant picker (req[1:0], last_grant -> next grant).
- Muxing, counters and the watchdog stay in the top module.

Test Plan:
- Reset state: assert wb_rst mid-GNT0 -> s_cyc_o=0 and gnt_o=00 within the same clock; all counters 0 after release.
- Single write: req0 only, write adr=0x0, dat=0x0000ABCD, sel=4'hF, slave acks 3 clocks after stb -> s_adr_o/s_dat_o match; m0_ack_o exactly 1 clock; xfer_cnt0_o=1; m1_ack_o stays 0.
- Tie-break: req0 and req1 rise in the same clock after reset -> GNT0 first. Then GNT1 after one IDLE bubble. A second tie -> GNT0 again (alternation).
- No preemption: m1 holds cyc for 4 ack beats while m0 requests -> m0 granted only after m1 drops cyc; xfer_cnt1_o=4.
- Saturation: force 65537 acked beats on port 1 -> xfer_cnt1_o=16'hFFFF.
- WB_ARB_TIMEOUT_EN, TIMEOUT=8: slave never acks -> m0_err_o pulses at the 8th stalled clock, s_cyc_o drops, and a pending m1 is granted two clocks later.
